cordic_phase_gen: RTL and testbench

//  Upstream stage of the pipelined CORDIC sin/cos core: an NCO-style phase generator.

---
 rtl/cordic_phase_gen.sv | 106 ++++++++++
 tb/tb_cordic_phase_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_gen.sv
// NCO-style phase generator feeding the pipelined CORDIC sin/cos core.
// Supports fixed tone and linear chirp (single or repeating), plus a valid delay line aligned to the CORDIC outputs.
module cordic_phase_gen #(
  parameter int unsigned LATENCY   = 32,
  parameter logic [15:0] GAIN_COMP = 16'd39797
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        stop,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_mode,
  input  logic [31:0] cfg_freq,
  input  logic [31:0] cfg_stop_freq,
  input  logic [31:0] cfg_step,
  input  logic [31:0] cfg_phase,
  input  logic [15:0] cfg_amp,
  output logic [31:0] angle,
  output logic [15:0] Xin,
  output logic [15:0] Yin,
  output logic        in_valid,
  output logic        sincos_valid,
  output logic        sweep_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, SWEEP, HOLD} state_t;

  state_t              state;
  logic [31:0]         phase;
  logic [31:0]         freq;
  logic [31:0]         start_f;
  logic [31:0]         stop_f;
  logic [31:0]         step_f;
  logic                rep;
  logic [LATENCY-1:0]  dline;
  logic [31:0]         amp_prod;
  logic [32:0]         nf;
  logic                accept;
  logic                adv;

  assign amp_prod     = {16'b0, cfg_amp} * {16'b0, GAIN_COMP};
  assign nf           = {1'b0, freq} + {1'b0, step_f};
  assign cfg_ready    = (state == IDLE) || (state == HOLD);
  assign busy         = (state == RUN) || (state == SWEEP);
  assign accept       = cfg_valid & cfg_ready & ~stop;
  assign adv          = en & (state != IDLE) & ~stop;
  assign Yin          = '0;
  assign sincos_valid = dline[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      freq       <= '0;
      start_f    <= '0;
      stop_f     <= '0;
      step_f     <= '0;
      rep        <= 1'b0;
      angle      <= '0;
      Xin        <= '0;
      in_valid   <= 1'b0;
      sweep_done <= 1'b0;
      dline      <= '0;
    end else begin
      in_valid   <= 1'b0;
      sweep_done <= 1'b0;
      dline      <= {dline[LATENCY-2:0], in_valid};
      if (stop) begin
        state <= IDLE;
      end else begin
        if (adv) begin
          angle    <= phase;
          in_valid <= 1'b1;
          phase    <= phase + freq;
          if (state == SWEEP) begin
            if (nf < {1'b0, stop_f}) begin
              freq <= nf[31:0];
            end else begin
              sweep_done <= 1'b1;
              if (rep) begin
                freq <= start_f;
              end else begin
                freq  <= stop_f;
                state <= HOLD;
              end
            end
          end
        end
        // A config accepted in HOLD still emits this cycle's sample but overrides the phase/freq update
        if (accept) begin
          phase   <= cfg_phase;
          freq    <= cfg_freq;
          start_f <= cfg_freq;
          stop_f  <= cfg_stop_freq;
          step_f  <= cfg_step;
          rep     <= (cfg_mode == 2'd2);
          Xin     <= amp_prod[31:16];
          state   <= ((cfg_mode == 2'd1) || (cfg_mode == 2'd2)) ? SWEEP : RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed self-checking bench for cordic_phase_gen: Xin scaling table, tone/wrap, enable gaps,
// async reset, single and repeating sweeps, and stop overriding a configuration.
module tb_cordic_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_mode = '0;
  logic [31:0] cfg_freq = '0;
  logic [31:0] cfg_stop_freq = '0;
  logic [31:0] cfg_step = '0;
  logic [31:0] cfg_phase = '0;
  logic [15:0] cfg_amp = '0;
  logic [31:0] angle;
  logic [15:0] Xin;
  logic [15:0] Yin;
  logic        in_valid;
  logic        sincos_valid;
  logic        sweep_done;
  logic        busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          cyc = 0;
  logic        hist [0:2047];

  typedef struct {
    logic [15:0] amp;
    logic [1:0]  mode;
    logic [15:0] exp_xin;
  } xin_vec_t;

  xin_vec_t xv [6];

  cordic_phase_gen #(.LATENCY(32), .GAIN_COMP(16'd39797)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_freq(cfg_freq), .cfg_stop_freq(cfg_stop_freq), .cfg_step(cfg_step),
    .cfg_phase(cfg_phase), .cfg_amp(cfg_amp),
    .angle(angle), .Xin(Xin), .Yin(Yin), .in_valid(in_valid),
    .sincos_valid(sincos_valid), .sweep_done(sweep_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; in_valid expectation is recorded so sincos_valid is checked 32 cycles later.
  task automatic step(input logic en_v, input logic exp_iv);
    en = en_v;
    @(posedge clk);
    #1;
    cyc++;
    hist[cyc] = exp_iv;
    chk1("in_valid", in_valid, exp_iv);
    chk1("sincos_valid", sincos_valid, (cyc >= 32) ? hist[cyc-32] : 1'b0);
  endtask

  task automatic cfg_set(input logic [1:0] m, input logic [31:0] f, input logic [31:0] sf,
                         input logic [31:0] st, input logic [31:0] ph, input logic [15:0] a);
    cfg_valid     = 1'b1;
    cfg_mode      = m;
    cfg_freq      = f;
    cfg_stop_freq = sf;
    cfg_step      = st;
    cfg_phase     = ph;
    cfg_amp       = a;
  endtask

  task automatic chk_reset_outputs();
    chk32("rst_angle", angle, 32'h0);
    chk32("rst_xin", {16'h0, Xin}, 32'h0);
    chk32("rst_yin", {16'h0, Yin}, 32'h0);
    chk1("rst_in_valid", in_valid, 1'b0);
    chk1("rst_sincos_valid", sincos_valid, 1'b0);
    chk1("rst_sweep_done", sweep_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cfg_ready", cfg_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] inc;
    logic [31:0] exp_phase;
    logic [31:0] exp_ang;
    logic        pat [5];
    logic [31:0] sw_ang [6];
    logic        sw_done [6];
    logic        sw_busy [6];
    logic [31:0] rp_ang [7];
    logic        rp_done [7];

    xv[0] = '{16'hFFFF, 2'd0, 16'd39796};
    xv[1] = '{16'h0000, 2'd3, 16'd0};
    xv[2] = '{16'h8000, 2'd1, 16'd19898};
    xv[3] = '{16'h0001, 2'd2, 16'd0};
    xv[4] = '{16'h0100, 2'd0, 16'd155};
    xv[5] = '{16'h1000, 2'd3, 16'd2487};
    pat     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sw_ang  = '{32'h1000, 32'h1100, 32'h1300, 32'h1600, 32'h1A00, 32'h1E00};
    sw_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    sw_busy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rp_ang  = '{32'h0, 32'h100, 32'h300, 32'h600, 32'h700, 32'h900, 32'hC00};
    rp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 2048; i++) hist[i] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    // Xin scaling and mode-to-state table
    for (int i = 0; i < 6; i++) begin
      cfg_set(xv[i].mode, 32'h0, 32'h0, 32'h0, 32'h0, xv[i].amp);
      step(1'b0, 1'b0);
      cfg_valid = 1'b0;
      chk32("xin_table", {16'h0, Xin}, {16'h0, xv[i].exp_xin});
      chk32("yin_table", {16'h0, Yin}, 32'h0);
      chk1("busy_after_accept", busy, 1'b1);
      chk1("cfg_ready_after_accept", cfg_ready, 1'b0);
      stop = 1'b1;
      step(1'b0, 1'b0);
      stop = 1'b0;
      chk1("busy_after_stop", busy, 1'b0);
      chk1("cfg_ready_after_stop", cfg_ready, 1'b1);
    end

    // Tone with wrap after 64 samples
    inc = 32'h0400_0000;
    cfg_set(2'd0, inc, 32'h0, 32'h0, 32'h0, 16'hFFFF);
    step(1'b0, 1'b0);
    cfg_valid = 1'b0;
    chk32("tone_xin", {16'h0, Xin}, 32'd39796);
    exp_phase = 32'h0;
    for (int k = 0; k < 66; k++) begin
      step(1'b1, 1'b1);
      chk32("tone_angle", angle, exp_phase);
      exp_phase = exp_phase + inc;
    end

    // Enable gaps: angle holds, sincos_valid replays the pattern
    exp_ang = angle;
    for (int k = 0; k < 5; k++) begin
      if (pat[k]) begin
        exp_ang   = exp_phase;
        exp_phase = exp_phase + inc;
      end
      step(pat[k], pat[k]);
      chk32("en_pattern_angle", angle, exp_ang);
    end
    for (int k = 0; k < 34; k++) step(1'b0, 1'b0);

    // Asynchronous reset mid-run clears outputs and the delay line
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    for (int i = 0; i < 2048; i++) hist[i] = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 35; k++) step(1'b1, 1'b0);

    // Single sweep into HOLD
    cfg_set(2'd1, 32'h100, 32'h400, 32'h100, 32'h1000, 16'hFFFF);
    step(1'b0, 1'b0);
    cfg_valid = 1'b0;
    chk1("sweep_busy_start", busy, 1'b1);
    chk1("sweep_cfg_ready_start", cfg_ready, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1);
      chk32("sweep_angle", angle, sw_ang[k]);
      chk1("sweep_done", sweep_done, sw_done[k]);
      chk1("sweep_busy", busy, sw_busy[k]);
      chk1("sweep_cfg_ready", cfg_ready, ~sw_busy[k]);
    end

    // Repeating sweep accepted from HOLD
    cfg_set(2'd2, 32'h100, 32'h400, 32'h100, 32'h0, 16'hFFFF);
    step(1'b0, 1'b0);
    cfg_valid = 1'b0;
    chk1("repeat_busy_start", busy, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b1);
      chk32("repeat_angle", angle, rp_ang[k]);
      chk1("repeat_sweep_done", sweep_done, rp_done[k]);
      chk1("repeat_busy", busy, 1'b1);
    end

    // stop wins over same-cycle cfg_valid; pending valids still drain
    stop = 1'b1;
    cfg_set(2'd0, 32'h5555, 32'h0, 32'h0, 32'hABCD, 16'h1234);
    step(1'b1, 1'b0);
    stop = 1'b0;
    cfg_valid = 1'b0;
    chk1("stop_busy", busy, 1'b0);
    chk1("stop_cfg_ready", cfg_ready, 1'b1);
    chk32("stop_xin_kept", {16'h0, Xin}, 32'd39796);
    chk32("stop_angle_held", angle, 32'hC00);
    chk1("stop_sweep_done", sweep_done, 1'b0);
    step(1'b0, 1'b0);
    chk1("stop_still_idle", busy, 1'b0);
    for (int k = 0; k < 34; k++) step(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
